// File: rtl/tone_channel_bank.sv
// Bank of independent triggerable square-wave voices with programmable period,
// duty and note length, plus a registered count of voices currently high.
module tone_channel_bank #(
    parameter int PERIOD_WIDTH = 20,
    parameter int LENGTH_WIDTH = 8,
    parameter int CHANNELS     = 4,
    parameter int MIX_WIDTH    = $clog2(CHANNELS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0]              trig,
    input  logic [CHANNELS-1:0]              stop,
    input  logic [CHANNELS*PERIOD_WIDTH-1:0] period,
    input  logic [CHANNELS*PERIOD_WIDTH-1:0] high_time,
    input  logic [CHANNELS*LENGTH_WIDTH-1:0] length,
    output logic [CHANNELS-1:0]              active,
    output logic [CHANNELS-1:0]              wave,
    output logic [MIX_WIDTH-1:0]             mix
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    function automatic logic [MIX_WIDTH-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [MIX_WIDTH-1:0] c;
        c = MIX_WIDTH'(0);
        for (int i = 0; i < CHANNELS; i++) begin
            c = c + MIX_WIDTH'(v[i]);
        end
        return c;
    endfunction

    logic [MIX_WIDTH-1:0] mix_r;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            state_t                  state_r,  state_nxt_s;
            logic [PERIOD_WIDTH-1:0] per_l_r,  per_l_nxt_s;
            logic [PERIOD_WIDTH-1:0] high_l_r, high_l_nxt_s;
            logic [PERIOD_WIDTH-1:0] cnt_r,    cnt_nxt_s;
            logic [LENGTH_WIDTH-1:0] len_l_r,  len_l_nxt_s;
            logic [LENGTH_WIDTH-1:0] rem_r,    rem_nxt_s;
            logic [PERIOD_WIDTH-1:0] period_s;
            logic [PERIOD_WIDTH-1:0] high_time_s;
            logic [LENGTH_WIDTH-1:0] length_s;
            logic                    wrap_s;

            assign period_s    = period[g*PERIOD_WIDTH +: PERIOD_WIDTH];
            assign high_time_s = high_time[g*PERIOD_WIDTH +: PERIOD_WIDTH];
            assign length_s    = length[g*LENGTH_WIDTH +: LENGTH_WIDTH];
            assign wrap_s      = (cnt_r == (per_l_r - PERIOD_WIDTH'(1)));

            // Next-state: stop beats trig beats free running; a period below 2 aborts the note.
            always_comb begin
                state_nxt_s  = state_r;
                per_l_nxt_s  = per_l_r;
                high_l_nxt_s = high_l_r;
                len_l_nxt_s  = len_l_r;
                cnt_nxt_s    = cnt_r;
                rem_nxt_s    = rem_r;
                if (stop[g]) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = PERIOD_WIDTH'(0);
                end else if (trig[g]) begin
                    if (period_s < PERIOD_WIDTH'(2)) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = PERIOD_WIDTH'(0);
                    end else begin
                        state_nxt_s  = ST_PLAY;
                        per_l_nxt_s  = period_s;
                        high_l_nxt_s = high_time_s;
                        len_l_nxt_s  = length_s;
                        rem_nxt_s    = length_s;
                        cnt_nxt_s    = PERIOD_WIDTH'(0);
                    end
                end else begin
                    case (state_r)
                        ST_PLAY: begin
                            if (wrap_s) begin
                                cnt_nxt_s = PERIOD_WIDTH'(0);
                                if (len_l_r == LENGTH_WIDTH'(0)) begin
                                    state_nxt_s = ST_PLAY;
                                end else if (rem_r == LENGTH_WIDTH'(1)) begin
                                    state_nxt_s = ST_IDLE;
                                end else begin
                                    rem_nxt_s = rem_r - LENGTH_WIDTH'(1);
                                end
                            end else begin
                                cnt_nxt_s = cnt_r + PERIOD_WIDTH'(1);
                            end
                        end
                        ST_IDLE: begin
                            state_nxt_s = ST_IDLE;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = PERIOD_WIDTH'(0);
                        end
                    endcase
                end
            end

            // Channel state and counter registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_r  <= ST_IDLE;
                    per_l_r  <= PERIOD_WIDTH'(0);
                    high_l_r <= PERIOD_WIDTH'(0);
                    len_l_r  <= LENGTH_WIDTH'(0);
                    cnt_r    <= PERIOD_WIDTH'(0);
                    rem_r    <= LENGTH_WIDTH'(0);
                end else begin
                    state_r  <= state_nxt_s;
                    per_l_r  <= per_l_nxt_s;
                    high_l_r <= high_l_nxt_s;
                    len_l_r  <= len_l_nxt_s;
                    cnt_r    <= cnt_nxt_s;
                    rem_r    <= rem_nxt_s;
                end
            end

            assign active[g] = (state_r == ST_PLAY);
            assign wave[g]   = (state_r == ST_PLAY) && (cnt_r < high_l_r);
        end
    endgenerate

    // Mix level lags the waves by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_r <= MIX_WIDTH'(0);
        end else begin
            mix_r <= popcount(wave);
        end
    end

    assign mix = mix_r;

endmodule

// File: tb/tb_tone_channel_bank.sv
// Self-checking bench for tone_channel_bank: directed scenarios plus random
// traffic compared against a time-based behavioural model of each note.
module tb_tone_channel_bank;

    localparam int PW = 20;
    localparam int LW = 8;
    localparam int CH = 4;
    localparam int MW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    trig = '0;
    logic [CH-1:0]    stop = '0;
    logic [CH*PW-1:0] period = '0;
    logic [CH*PW-1:0] high_time = '0;
    logic [CH*LW-1:0] length = '0;
    logic [CH-1:0]    active;
    logic [CH-1:0]    wave;
    logic [MW-1:0]    mix;

    int checks = 0;
    int errors = 0;

    tone_channel_bank #(.PERIOD_WIDTH(PW), .LENGTH_WIDTH(LW), .CHANNELS(CH), .MIX_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .trig(trig), .stop(stop), .period(period),
        .high_time(high_time), .length(length), .active(active), .wave(wave), .mix(mix)
    );

    always #5 clk = ~clk;

    // Model: a note is its start time plus parameters; outputs follow from elapsed time.
    longint  t = 0;
    bit      m_play [CH];
    longint  m_start[CH];
    longint  m_per  [CH];
    longint  m_high [CH];
    longint  m_len  [CH];
    logic [MW-1:0] exp_mix = '0;

    function automatic bit m_act(int c);
        longint el;
        el = t - m_start[c];
        return m_play[c] && (m_len[c] == 0 || el < m_len[c] * m_per[c]);
    endfunction

    function automatic bit m_wav(int c);
        if (!m_act(c)) return 1'b0;
        return ((t - m_start[c]) % m_per[c]) < m_high[c];
    endfunction

    function automatic int m_count();
        int n;
        n = 0;
        for (int c = 0; c < CH; c++) n += int'(m_wav(c));
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t       <= 0;
            exp_mix <= '0;
            for (int c = 0; c < CH; c++) m_play[c] <= 1'b0;
        end else begin
            t       <= t + 1;
            exp_mix <= MW'(m_count());
            for (int c = 0; c < CH; c++) begin
                if (stop[c]) begin
                    m_play[c] <= 1'b0;
                end else if (trig[c]) begin
                    if (period[c*PW +: PW] < 2) begin
                        m_play[c] <= 1'b0;
                    end else begin
                        m_play[c]  <= 1'b1;
                        m_start[c] <= t + 1;
                        m_per[c]   <= longint'(period[c*PW +: PW]);
                        m_high[c]  <= longint'(high_time[c*PW +: PW]);
                        m_len[c]   <= longint'(length[c*LW +: LW]);
                    end
                end
            end
        end
    end

    task automatic set_ch(int c, int p, int h, int l);
        period[c*PW +: PW]    = PW'(p);
        high_time[c*PW +: PW] = PW'(h);
        length[c*LW +: LW]    = LW'(l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        trig = '0;
        stop = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (active !== 4'h0 || wave !== 4'h0 || mix !== 3'd0) begin
            errors++;
            $display("FAIL reset: active=%b wave=%b mix=%0d required 0/0/0", active, wave, mix);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (active !== 4'h0 || wave !== 4'h0 || mix !== 3'd0) begin
                errors++;
                $display("FAIL idle k=%0d: active=%b wave=%b mix=%0d required 0/0/0", k, active, wave, mix);
            end
        end
    endtask

    task automatic test_basic_note();
        int act_cnt;
        act_cnt = 0;
        set_ch(0, 10, 3, 2);
        trig[0] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            act_cnt += int'(active[0]);
            checks++;
            if (wave[0] !== ((k < 20) && (k % 10 < 3)) || active[0] !== (k < 20)) begin
                errors++;
                $display("FAIL basic k=%0d: wave=%b active=%b required %b/%b", k, wave[0], active[0],
                         (k < 20) && (k % 10 < 3), k < 20);
            end
            checks++;
            if (mix !== exp_mix) begin
                errors++;
                $display("FAIL basic_mix k=%0d: mix=%0d required %0d", k, mix, exp_mix);
            end
        end
        checks++;
        if (act_cnt != 20) begin
            errors++;
            $display("FAIL basic_len: active cycles=%0d required 20", act_cnt);
        end
    endtask

    task automatic test_continuous_stop();
        set_ch(1, 4, 2, 0);
        trig[1] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            checks++;
            if (wave[1] !== (k % 4 < 2) || active[1] !== 1'b1 || mix !== exp_mix) begin
                errors++;
                $display("FAIL cont k=%0d: wave=%b active=%b mix=%0d required %b/1/%0d", k, wave[1],
                         active[1], mix, k % 4 < 2, exp_mix);
            end
        end
        stop[1] = 1'b1;
        tick();
        checks++;
        if (active[1] !== 1'b0 || wave[1] !== 1'b0) begin
            errors++;
            $display("FAIL stop: active=%b wave=%b required 0/0", active[1], wave[1]);
        end
        tick();
        checks++;
        if (mix !== exp_mix) begin
            errors++;
            $display("FAIL stop_mix: mix=%0d required %0d", mix, exp_mix);
        end
    endtask

    task automatic test_retrigger_priority();
        set_ch(2, 10, 3, 0);
        trig[2] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        set_ch(2, 6, 6, 3);
        trig[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (active[2] !== (k < 18) || wave[2] !== (k < 18) || mix !== exp_mix) begin
                errors++;
                $display("FAIL retrig k=%0d: active=%b wave=%b mix=%0d required %b/%b/%0d", k,
                         active[2], wave[2], mix, k < 18, k < 18, exp_mix);
            end
        end
        set_ch(2, 6, 3, 0);
        trig[2] = 1'b1;
        tick();
        trig[2] = 1'b1;
        stop[2] = 1'b1;
        tick();
        checks++;
        if (active[2] !== 1'b0 || wave[2] !== 1'b0) begin
            errors++;
            $display("FAIL trig_stop: active=%b wave=%b required 0/0", active[2], wave[2]);
        end
        trig[2] = 1'b1;
        tick();
        set_ch(2, 1, 3, 0);
        trig[2] = 1'b1;
        tick();
        checks++;
        if (active[2] !== 1'b0 || wave[2] !== 1'b0) begin
            errors++;
            $display("FAIL period1: active=%b wave=%b required 0/0", active[2], wave[2]);
        end
    endtask

    task automatic test_edge_duty();
        set_ch(3, 5, 0, 2);
        trig[3] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            checks++;
            if (active[3] !== (k < 10) || wave[3] !== 1'b0) begin
                errors++;
                $display("FAIL duty0 k=%0d: active=%b wave=%b required %b/0", k, active[3], wave[3], k < 10);
            end
        end
        set_ch(3, 8, 15, 1);
        trig[3] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (active[3] !== (k < 8) || wave[3] !== (k < 8)) begin
                errors++;
                $display("FAIL dutyfull k=%0d: active=%b wave=%b required %b/%b", k, active[3], wave[3],
                         k < 8, k < 8);
            end
        end
    endtask

    task automatic test_mix();
        logic [MW-1:0] want;
        stop = 4'hF;
        tick();
        tick();
        for (int c = 0; c < CH; c++) set_ch(c, 8, 4, 0);
        trig = 4'hF;
        for (int k = 0; k < 24; k++) begin
            tick();
            want = (k >= 1 && ((k - 1) % 8) < 4) ? 3'd4 : 3'd0;
            checks++;
            if (mix !== want || wave !== (((k % 8) < 4) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL mix k=%0d: mix=%0d wave=%b required %0d/%b", k, mix, wave, want,
                         ((k % 8) < 4) ? 4'hF : 4'h0);
            end
        end
        stop = 4'hF;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < CH; c++) begin
                set_ch(c, int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 4)));
                trig[c] = ($urandom_range(0, 19) == 0);
                stop[c] = ($urandom_range(0, 59) == 0);
            end
            tick();
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (active[c] !== m_act(c) || wave[c] !== m_wav(c)) begin
                    errors++;
                    $display("FAIL random k=%0d ch%0d: active=%b wave=%b required %b/%b", k, c,
                             active[c], wave[c], m_act(c), m_wav(c));
                end
            end
            checks++;
            if (mix !== exp_mix) begin
                errors++;
                $display("FAIL random_mix k=%0d: mix=%0d required %0d", k, mix, exp_mix);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_note();
        test_continuous_stop();
        test_retrigger_priority();
        test_edge_duty();
        test_mix();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
